// File: rtl/alu_muldiv_pkg.sv
// Shared op codes, FSM encoding and decode helper for the iterative mul/div unit.
package alu_muldiv_pkg;
  localparam logic [3:0] MULT  = 4'b1000;
  localparam logic [3:0] MULTU = 4'b1001;
  localparam logic [3:0] DIV   = 4'b1010;
  localparam logic [3:0] DIVU  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_e;

  // bit1 selects divide, bit0 selects unsigned
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op & 4'b1100) == 4'b1000;
  endfunction
endpackage

// File: rtl/alu_muldiv_sign_fix.sv
// Combinational magnitude extraction on entry and sign restoration on exit.
module alu_muldiv_sign_fix (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  input  logic [63:0] acc_i,
  input  logic        is_div_i,
  input  logic        sa_i,
  input  logic        sb_i,
  input  logic        dbz_i,
  output logic        sa_o,
  output logic        sb_o,
  output logic [31:0] abs_a_o,
  output logic [31:0] abs_b_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  assign sa_o    = signed_i & a_i[31];
  assign sb_o    = signed_i & b_i[31];
  assign abs_a_o = sa_o ? -a_i : a_i;
  assign abs_b_o = sb_o ? -b_i : b_i;

  assign prod = (sa_i ^ sb_i) ? -acc_i : acc_i;
  assign quo  = (sa_i ^ sb_i) ? -acc_i[31:0] : acc_i[31:0];
  // remainder follows the dividend; with B==0 this reproduces the original A
  assign rem  = sa_i ? -acc_i[63:32] : acc_i[63:32];

  always_comb begin
    hi_o = prod[63:32];
    lo_o = prod[31:0];
    if (is_div_i) begin
      hi_o = rem;
      lo_o = dbz_i ? 32'hFFFF_FFFF : quo;
    end
  end
endmodule

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply / restoring divide, 33-cycle fixed latency, HI/LO result.
module alu_muldiv
  import alu_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  alu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);
  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic        dbz_q, dbz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;
  logic        div_by_zero_q, div_by_zero_d;

  logic        sa_in, sb_in;
  logic [31:0] abs_a, abs_b, fix_hi, fix_lo;
  logic [32:0] add_s, sub_s;

  alu_muldiv_sign_fix u_sign_fix (
    .a_i      (A),
    .b_i      (B),
    .signed_i (~alu_op[0]),
    .acc_i    (acc_q),
    .is_div_i (is_div_q),
    .sa_i     (sa_q),
    .sb_i     (sb_q),
    .dbz_i    (dbz_q),
    .sa_o     (sa_in),
    .sb_o     (sb_in),
    .abs_a_o  (abs_a),
    .abs_b_o  (abs_b),
    .hi_o     (fix_hi),
    .lo_o     (fix_lo)
  );

  // multiply: add into upper half then shift right; divide: trial-subtract the shifted remainder
  assign add_s = {1'b0, acc_q[63:32]} + {1'b0, opb_q};
  assign sub_s = acc_q[63:31] - {1'b0, opb_q};

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    opb_d         = opb_q;
    cnt_d         = cnt_q;
    is_div_d      = is_div_q;
    sa_d          = sa_q;
    sb_d          = sb_q;
    dbz_d         = dbz_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    done_d        = 1'b0;
    div_by_zero_d = div_by_zero_q;
    case (state_q)
      IDLE: if (start && is_muldiv(alu_op)) begin
        state_d       = CALC;
        cnt_d         = 5'd31;
        acc_d         = {32'd0, abs_a};
        opb_d         = abs_b;
        is_div_d      = alu_op[1];
        sa_d          = sa_in;
        sb_d          = sb_in;
        dbz_d         = alu_op[1] && (B == 32'd0);
        div_by_zero_d = 1'b0;
      end
      CALC: begin
        if (is_div_q)
          acc_d = sub_s[32] ? {acc_q[62:0], 1'b0} : {sub_s[31:0], acc_q[30:0], 1'b1};
        else
          acc_d = acc_q[0] ? {add_s, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = SIGN;
      end
      SIGN: begin
        hi_d          = fix_hi;
        lo_d          = fix_lo;
        done_d        = 1'b1;
        div_by_zero_d = dbz_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      opb_q         <= '0;
      cnt_q         <= '0;
      is_div_q      <= 1'b0;
      sa_q          <= 1'b0;
      sb_q          <= 1'b0;
      dbz_q         <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      opb_q         <= opb_d;
      cnt_q         <= cnt_d;
      is_div_q      <= is_div_d;
      sa_q          <= sa_d;
      sb_q          <= sb_d;
      dbz_q         <= dbz_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = div_by_zero_q;
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative multiply/divide unit in the execute stage, sitting beside `alu_logic_arithmetic` and driven by the same `alu_op`/`A`/`B` operand bus. It runs signed and unsigned 32×32 multiply and 32/32 divide over a fixed number of cycles and holds the 64-bit result in HI/LO registers. The result mux reads HI/LO; control stalls the core while `busy` is high.

## Interface
- No parameters; width is fixed at 32.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only while idle.
- `alu_op`  in  4  operation: `MULT`, `MULTU`, `DIV`, `DIVU`. Other codes make `start` a no-op.
- `A`  in  32  multiplicand or dividend.
- `B`  in  32  multiplier or divisor.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO update.
- `hi`  out  32  product[63:32] or remainder.
- `lo`  out  32  product[31:0] or quotient.
- `div_by_zero`  out  1  set with `done` when a DIV/DIVU had B==0; cleared on the next accepted start.

## Operation
- FSM states: IDLE, CALC, SIGN.
- IDLE + `start` + muldiv op:
  - latch op, sign flags, |A|, |B| (unsigned ops use the raw values);
  - count=31; go to CALC.
- CALC, one iteration per cycle:
  - MUL: shift-add, radix 2.
  - DIV: restoring, radix 2.
  - When count==0, go to SIGN.
- SIGN:
  - fix up signs and write HI/LO;
  - pulse `done`; go to IDLE.
- Sign rules:
  - MULT: negate the 64-bit product if sign(A)^sign(B).
  - DIV: quotient sign = sign(A)^sign(B); remainder sign = sign(A).
- Corner results:
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
  - B==0 on DIV/DIVU gives lo=0xFFFFFFFF, hi=A (original dividend), `div_by_zero`=1, same latency as a normal divide.
- Operands:
  - A/B/alu_op changes while busy are ignored (values are latched).
  - `start` while busy is ignored; it is not queued.
- HI/LO hold their value until the next `done`.

## Timing
- Reset (async, takes effect immediately):
  - state=IDLE;
  - `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0.
- Start accepted at edge E0:
  - `busy`=1 from E0 through E33 (exclusive);
  - 32 CALC edges: E1..E32;
  - SIGN at edge E33: `hi`/`lo` valid, `done`=1, `busy`=0 in the same cycle.
- Fixed latency: 33 cycles from the accepting edge to `done`.
- `done` lasts exactly one cycle.
- `start` may be asserted in the `done` cycle; state is IDLE, so it is accepted back-to-back.
- Reset mid-operation aborts: no `done`, and HI/LO return to 0.
- `busy` is a registered output; there is no combinational path from `start` to `busy`.

## Structure
- `param.v` gains the op codes `MULT`=4'b1000, `MULTU`=4'b1001, `DIV`=4'b1010, `DIVU`=4'b1011 (disjoint from `AND`/`OR`/`XOR`), plus the FSM state encodings.
- Single module. An optional sub-module `muldiv_sign_fix` holds the combinational negate/abs logic.
- Datapath registers:
  - 64-bit accumulator/remainder-quotient register;
  - 32-bit operand register;
  - 5-bit counter;
  - op/sign flags.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; `done` exactly 33 cycles after the start edge; `busy` high for 33 cycles.
- MULT −3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 → lo=0xFFFFFFFF, hi=0x00000064, `div_by_zero`=1 with `done`. The next start clears the flag.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, `div_by_zero`=0.
- Start MULTU 5×6, pulse `start` again at cycle 10 with different operands → ignored; result hi=0, lo=30. A new start in the `done` cycle is accepted.
- Start DIVU, deassert `rst_n` at cycle 10 → `busy`/`hi`/`lo` go to 0 immediately; no `done` appears within 40 cycles.
